// File: rtl/crc_pkg.sv
// Shared definitions for the 9-bit CRC frame sequencer: FSM encoding,
// generator constants and a width helper.
package crc_pkg;

  localparam int CRC9_W = 9;
  localparam logic [CRC9_W-1:0] GEN_POLY9 = 9'h103;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  // Bits needed to hold values 0 .. value-1.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

endpackage

// File: rtl/crc_frame_sequencer_if.sv
// Message-in / remainder-out handshake bundle of the CRC frame sequencer.
interface crc_frame_sequencer_if
  import crc_pkg::*;
#(
    parameter int MSG_W = 10,
    parameter int CRC_W = CRC9_W
);

    logic             in_valid;
    logic             in_ready;
    logic [MSG_W-1:0] msg_in;
    logic             out_valid;
    logic             out_ready;
    logic [CRC_W-1:0] crc_out;

    modport master (
        output in_valid, msg_in, out_ready,
        input  in_ready, out_valid, crc_out
    );

    modport slave (
        input  in_valid, msg_in, out_ready,
        output in_ready, out_valid, crc_out
    );

endinterface

// File: rtl/crc_lfsr_step.sv
// Combinational multi-bit LFSR step: up to LANES message bits, MSB first,
// with lanes at or beyond nbits leaving the register untouched.
module crc_lfsr_step
  import crc_pkg::*;
#(
    parameter int                CRC_W = CRC9_W,
    parameter logic [CRC_W-1:0]  POLY  = GEN_POLY9,
    parameter int                LANES = 4,
    parameter int                NB_W  = clog2(LANES + 1)
) (
    input  logic [CRC_W-1:0] lfsr_in,
    input  logic [LANES-1:0] data,
    input  logic [NB_W-1:0]  nbits,
    output logic [CRC_W-1:0] lfsr_out
);

    logic [CRC_W-1:0] acc;
    logic             fb;

    // NOTE: every variable gets a default at the top of an always_comb so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        acc = lfsr_in;
        fb  = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            if (NB_W'(i) < nbits) begin
                fb  = acc[CRC_W-1] ^ data[LANES-1-i];
                acc = {acc[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
            end
        end
        lfsr_out = acc;
    end

endmodule

// File: rtl/crc_frame_sequencer.sv
// Frame sequencer for the 9-bit CRC datapath: accepts a message, steps it
// through the LFSR LANES bits per clock and holds the remainder until taken.
module crc_frame_sequencer
  import crc_pkg::*;
#(
    parameter int               MSG_W = 10,
    parameter int               CRC_W = CRC9_W,
    parameter logic [CRC_W-1:0] POLY  = GEN_POLY9,
    parameter int               LANES = 4,
    parameter int               CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 abort,
    crc_frame_sequencer_if.slave bus,
    output logic                 busy,
    output logic [CNT_W-1:0]     frames_done
);

    localparam int REM_W = clog2(MSG_W + 1);
    localparam int NB_W  = clog2(LANES + 1);

    state_t           state_q, state_d;
    logic [MSG_W-1:0] shreg_q;
    logic [REM_W-1:0] rem_q;
    logic [REM_W-1:0] n_full;
    logic [NB_W-1:0]  nbits;
    logic [CRC_W-1:0] lfsr_q, lfsr_next, crc_q;
    logic             out_valid_q;
    logic [CNT_W-1:0] frames_q;
    logic             last_chunk;
    logic             accept, deliver, step_en, in_ready_c;

    // Bits consumed this cycle: a full lane group, or whatever is left.
    assign n_full     = (rem_q < REM_W'(LANES)) ? rem_q : REM_W'(LANES);
    assign nbits      = NB_W'(n_full);
    assign last_chunk = (rem_q <= REM_W'(LANES));

    crc_lfsr_step #(
        .CRC_W (CRC_W),
        .POLY  (POLY),
        .LANES (LANES),
        .NB_W  (NB_W)
    ) u_step (
        .lfsr_in  (lfsr_q),
        .data     (shreg_q[MSG_W-1 -: LANES]),
        .nbits    (nbits),
        .lfsr_out (lfsr_next)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (bus.in_valid)  state_d = RUN;
                RUN:     if (last_chunk)    state_d = HOLD;
                HOLD:    if (bus.out_ready) state_d = IDLE;
                default:                    state_d = IDLE;
            endcase
        end
    end

    // Abort outranks both handshakes, so it masks accept and deliver here.
    always_comb begin
        in_ready_c = 1'b0;
        busy       = 1'b1;
        accept     = 1'b0;
        deliver    = 1'b0;
        step_en    = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready_c = 1'b1;
                busy       = 1'b0;
                accept     = bus.in_valid && !abort;
            end
            RUN:     step_en = !abort;
            HOLD:    deliver = bus.out_ready && !abort;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shreg_q     <= '0;
            rem_q       <= '0;
            lfsr_q      <= '0;
            crc_q       <= '0;
            out_valid_q <= 1'b0;
            frames_q    <= '0;
        end else begin
            if (accept) begin
                shreg_q <= bus.msg_in;
                lfsr_q  <= '0;
                rem_q   <= REM_W'(MSG_W);
            end else if (step_en) begin
                shreg_q <= shreg_q << LANES;
                lfsr_q  <= lfsr_next;
                rem_q   <= rem_q - n_full;
                if (last_chunk) crc_q <= lfsr_next;
            end

            if (abort)                       out_valid_q <= 1'b0;
            else if (step_en && last_chunk)  out_valid_q <= 1'b1;
            else if (deliver)                out_valid_q <= 1'b0;

            if (deliver) frames_q <= frames_q + CNT_W'(1);
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_q;
    assign bus.crc_out   = crc_q;
    assign frames_done   = frames_q;

endmodule

// File: tb/tb_crc_frame_sequencer.sv
// Bench for crc_frame_sequencer: three instances (LANES 4/1/3, the last with a
// 2-bit frame counter) driven by directed vectors, corner sequences and random frames.
module tb_crc_frame_sequencer;

    logic       clk;
    logic       reset;
    logic       in_valid  [3];
    logic       out_ready [3];
    logic       abort     [3];
    logic [9:0] msg_in    [3];
    logic       in_ready  [3];
    logic       out_valid [3];
    logic [8:0] crc_out   [3];
    logic       busy      [3];
    logic [7:0] fd        [3];

    int         n_checks = 0;
    int         n_pass   = 0;
    logic [7:0] exp_fd   [3];
    logic [8:0] last_crc [3];
    int         lat_of   [3] = '{3, 10, 4};
    logic [7:0] fd_mask  [3] = '{8'hFF, 8'hFF, 8'h03};

    typedef struct {
        logic [9:0] msg;
        logic [8:0] crc;
    } vec_t;

    vec_t vecs [10];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int L = (g == 0) ? 4 : ((g == 1) ? 1 : 3);
        localparam int C = (g == 2) ? 2 : 8;
        logic [C-1:0] fd_w;
        logic         busy_w;

        crc_frame_sequencer_if #(.MSG_W(10), .CRC_W(9)) bus ();

        assign bus.in_valid  = in_valid[g];
        assign bus.msg_in    = msg_in[g];
        assign bus.out_ready = out_ready[g];
        assign in_ready[g]   = bus.in_ready;
        assign out_valid[g]  = bus.out_valid;
        assign crc_out[g]    = bus.crc_out;
        assign busy[g]       = busy_w;
        assign fd[g]         = 8'(fd_w);

        crc_frame_sequencer #(
            .MSG_W (10),
            .CRC_W (9),
            .POLY  (9'h103),
            .LANES (L),
            .CNT_W (C)
        ) dut (
            .clk         (clk),
            .reset       (reset),
            .abort       (abort[g]),
            .bus         (bus),
            .busy        (busy_w),
            .frames_done (fd_w)
        );
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Long division of msg(y)*y^9 by g(y) = y^9+y^8+y+1.
    function automatic logic [8:0] crc_ref(input logic [9:0] msg);
        logic [18:0] v;
        v = {msg, 9'b0};
        for (int i = 18; i >= 9; i--)
            if (v[i]) v = v ^ (19'h303 << (i - 9));
        return v[8:0];
    endfunction

    task automatic run_frame(input int idx, input logic [9:0] msg, input logic [8:0] exp_crc,
                             input int exp_lat, input int stall, input string tag);
        int cycles;
        in_valid[idx]  = 1'b1;
        msg_in[idx]    = msg;
        out_ready[idx] = (stall == 0);
        tick();
        in_valid[idx] = 1'b0;
        check({tag, " in_ready low in RUN"}, in_ready[idx], 0);
        check({tag, " busy in RUN"}, busy[idx], 1);
        cycles = 0;
        while (out_valid[idx] !== 1'b1 && cycles < 40) begin
            tick();
            cycles++;
        end
        check({tag, " latency"}, cycles, exp_lat);
        check({tag, " crc"}, crc_out[idx], exp_crc);
        if (stall > 0) begin
            repeat (stall) tick();
            check({tag, " crc held"}, crc_out[idx], exp_crc);
            out_ready[idx] = 1'b1;
        end
        tick();
        exp_fd[idx] = (exp_fd[idx] + 8'd1) & fd_mask[idx];
        check({tag, " frames_done"}, fd[idx], exp_fd[idx]);
        check({tag, " out_valid cleared"}, out_valid[idx], 0);
        out_ready[idx] = 1'b0;
        last_crc[idx]  = exp_crc;
    endtask

    initial begin
        int         seen;
        int         wrap_seq [5] = '{1, 2, 3, 0, 1};
        logic [9:0] rmsg;

        vecs[0] = '{10'b1100000011, 9'h000};
        vecs[1] = '{10'h001, 9'h103};
        vecs[2] = '{10'h200, 9'h004};
        vecs[3] = '{10'h002, 9'h105};
        vecs[4] = '{10'h004, 9'h109};
        vecs[5] = '{10'h008, 9'h111};
        vecs[6] = '{10'h080, 9'h001};
        vecs[7] = '{10'h100, 9'h002};
        vecs[8] = '{10'h003, 9'h006};
        vecs[9] = '{10'h000, 9'h000};

        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid[i] = 1'b0; out_ready[i] = 1'b0; abort[i] = 1'b0; msg_in[i] = '0;
            exp_fd[i] = '0; last_crc[i] = '0;
        end

        // Reset state
        repeat (2) tick();
        for (int i = 0; i < 3; i++) begin
            check($sformatf("reset in_ready[%0d]", i), in_ready[i], 1);
            check($sformatf("reset out_valid[%0d]", i), out_valid[i], 0);
            check($sformatf("reset busy[%0d]", i), busy[i], 0);
            check($sformatf("reset crc_out[%0d]", i), crc_out[i], 0);
            check($sformatf("reset frames_done[%0d]", i), fd[i], 0);
        end
        reset = 1'b1;
        tick();

        // Directed vectors, LANES=4
        for (int k = 0; k < 10; k++)
            run_frame(0, vecs[k].msg, vecs[k].crc, 3, 0, $sformatf("vec%0d", k));

        // Backpressure in HOLD, with a competing in_valid that must be ignored
        in_valid[0] = 1'b1; msg_in[0] = 10'h001; out_ready[0] = 1'b0;
        tick();
        msg_in[0] = 10'h200;
        repeat (3) tick();
        for (int s = 0; s < 5; s++) begin
            check($sformatf("bp out_valid c%0d", s), out_valid[0], 1);
            check($sformatf("bp crc c%0d", s), crc_out[0], 9'h103);
            check($sformatf("bp in_ready c%0d", s), in_ready[0], 0);
            check($sformatf("bp frames_done c%0d", s), fd[0], exp_fd[0]);
            tick();
        end
        in_valid[0] = 1'b0; out_ready[0] = 1'b1;
        tick();
        exp_fd[0] = exp_fd[0] + 8'd1;
        check("bp release frames_done", fd[0], exp_fd[0]);
        check("bp release out_valid", out_valid[0], 0);
        check("bp release idle", busy[0], 0);
        out_ready[0] = 1'b0;
        last_crc[0] = 9'h103;

        // Abort in the second RUN cycle
        run_frame(0, 10'h008, 9'h111, 3, 0, "pre-abort");
        in_valid[0] = 1'b1; msg_in[0] = 10'h002; out_ready[0] = 1'b1;
        tick();
        in_valid[0] = 1'b0;
        tick();
        abort[0] = 1'b1;
        tick();
        abort[0] = 1'b0;
        check("abort run busy", busy[0], 0);
        check("abort run in_ready", in_ready[0], 1);
        seen = 0;
        repeat (5) begin
            if (out_valid[0] === 1'b1) seen = 1;
            tick();
        end
        check("abort run out_valid never", seen, 0);
        check("abort run crc kept", crc_out[0], last_crc[0]);
        check("abort run frames_done", fd[0], exp_fd[0]);
        out_ready[0] = 1'b0;
        run_frame(0, 10'h001, 9'h103, 3, 0, "post-abort");

        // Abort coinciding with an accept
        in_valid[0] = 1'b1; msg_in[0] = 10'h004; abort[0] = 1'b1;
        tick();
        in_valid[0] = 1'b0; abort[0] = 1'b0;
        check("abort accept busy", busy[0], 0);

        // Abort coinciding with a deliver
        in_valid[0] = 1'b1; msg_in[0] = 10'h002; out_ready[0] = 1'b0;
        tick();
        in_valid[0] = 1'b0;
        repeat (3) tick();
        check("abort hold reached", out_valid[0], 1);
        abort[0] = 1'b1; out_ready[0] = 1'b1;
        tick();
        abort[0] = 1'b0; out_ready[0] = 1'b0;
        check("abort hold out_valid", out_valid[0], 0);
        check("abort hold frames_done", fd[0], exp_fd[0]);
        check("abort hold crc kept", crc_out[0], 9'h105);
        check("abort hold busy", busy[0], 0);

        // Asynchronous reset mid-RUN
        in_valid[0] = 1'b1; msg_in[0] = 10'h080;
        tick();
        in_valid[0] = 1'b0;
        tick();
        #2 reset = 1'b0;
        #1;
        check("async rst in_ready", in_ready[0], 1);
        check("async rst out_valid", out_valid[0], 0);
        check("async rst busy", busy[0], 0);
        check("async rst crc_out", crc_out[0], 0);
        check("async rst frames_done", fd[0], 0);
        #2 reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            exp_fd[i] = '0; last_crc[i] = '0;
        end
        tick();
        run_frame(0, 10'b1100000011, 9'h000, 3, 0, "post-reset");

        // LANES=1: same CRCs, latency 10
        for (int k = 0; k < 3; k++)
            run_frame(1, vecs[k].msg, vecs[k].crc, 10, 0, $sformatf("l1 vec%0d", k));

        // LANES=3, CNT_W=2: latency 4 and counter wrap 1,2,3,0,1
        for (int k = 0; k < 5; k++) begin
            run_frame(2, vecs[k].msg, vecs[k].crc, 4, 0, $sformatf("l3 vec%0d", k));
            check($sformatf("wrap seq %0d", k), fd[2], wrap_seq[k]);
        end

        // Random frames against the long-division model
        for (int i = 0; i < 1000; i++) begin
            rmsg = 10'($urandom_range(0, 1023));
            run_frame(i % 3, rmsg, crc_ref(rmsg), lat_of[i % 3], int'($urandom_range(0, 2)),
                      $sformatf("rand%0d msg=%0h", i, rmsg));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
